// File: rtl/alu_mem_unit.sv
// Execution/storage slice: 1024x16 instruction memory, 16-bit ALU with {Z,N,C,V} flags,
// and a 512x16 data memory with stack push/pop. Define ALU_MUL_EN to add opcode 21 (MUL).
module alu_mem_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        im_en_write,
    input  logic [9:0]  im_address,
    input  logic [15:0] im_data_in,
    output logic [15:0] im_data_out,
    input  logic        alu_store,
    input  logic [15:0] alu_a,
    input  logic [15:0] alu_b,
    input  logic [5:0]  alu_opcode,
    output logic [15:0] alu_out,
    output logic [3:0]  alu_flags,
    input  logic        dm_store,
    input  logic        dm_push,
    input  logic        dm_pop,
    input  logic [8:0]  dm_address,
    input  logic [15:0] dm_rez,
    input  logic [15:0] dm_sp,
    output logic [15:0] dm_data_out
);

    localparam logic [5:0] OpHlt = 6'd0;
    localparam logic [5:0] OpBrz = 6'd3;
    localparam logic [5:0] OpBra = 6'd7;
    localparam logic [5:0] OpAdd = 6'd10;
    localparam logic [5:0] OpSub = 6'd11;
    localparam logic [5:0] OpLsr = 6'd12;
    localparam logic [5:0] OpLsl = 6'd13;
    localparam logic [5:0] OpMov = 6'd16;
    localparam logic [5:0] OpAnd = 6'd17;
    localparam logic [5:0] OpOr  = 6'd18;
    localparam logic [5:0] OpXor = 6'd19;
    localparam logic [5:0] OpNot = 6'd20;
    localparam logic [5:0] OpCmp = 6'd24;
    localparam logic [5:0] OpTst = 6'd25;
    localparam logic [5:0] OpInc = 6'd26;
    localparam logic [5:0] OpDec = 6'd27;
`ifdef ALU_MUL_EN
    localparam logic [5:0] OpMul = 6'd21;
`endif

    logic [15:0] im_q [1024];
    logic [15:0] dm_q [512];
    logic [8:0]  pop_idx;
    logic        unused_sp_hi;

    // IM is program storage: deliberately not reset so a restart keeps the loaded program.
    always_ff @(posedge clk) begin
        if (im_en_write) begin
            im_q[im_address] <= im_data_in;
        end
    end

    assign im_data_out = im_q[im_address];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 512; i++) begin
                dm_q[i] <= '0;
            end
        end else if (dm_push) begin
            dm_q[dm_sp[8:0]] <= dm_rez;
        end else if (dm_store) begin
            dm_q[dm_address] <= dm_rez;
        end
    end

    // sp points at the next free slot, so the top of stack sits one word above it.
    assign pop_idx      = dm_sp[8:0] + 9'd1;
    assign dm_data_out  = dm_pop ? dm_q[pop_idx] : dm_q[dm_address];
    assign unused_sp_hi = ^dm_sp[15:9];

    logic [15:0] res;
    logic        c_flag;
    logic        v_flag;
    logic        known;
    logic [16:0] wide;
    logic [31:0] sh;
`ifdef ALU_MUL_EN
    logic [31:0] prod;
`endif

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        known  = 1'b1;
        wide   = '0;
        sh     = '0;
`ifdef ALU_MUL_EN
        prod   = '0;
`endif
        case (alu_opcode)
            OpHlt, OpBrz, OpBra: res = '0;
            OpAdd: begin
                wide   = {1'b0, alu_a} + {1'b0, alu_b};
                res    = wide[15:0];
                c_flag = wide[16];
                v_flag = (alu_a[15] == alu_b[15]) && (res[15] != alu_a[15]);
            end
            OpSub, OpCmp: begin
                wide   = {1'b0, alu_a} - {1'b0, alu_b};
                res    = wide[15:0];
                c_flag = wide[16];
                v_flag = (alu_a[15] != alu_b[15]) && (res[15] != alu_a[15]);
            end
            OpInc: begin
                wide   = {1'b0, alu_a} + 17'd1;
                res    = wide[15:0];
                c_flag = wide[16];
                v_flag = !alu_a[15] && res[15];
            end
            OpDec: begin
                wide   = {1'b0, alu_a} - 17'd1;
                res    = wide[15:0];
                c_flag = wide[16];
                v_flag = alu_a[15] && !res[15];
            end
            // Shift through a 32-bit window so the bit just past the result is the carry.
            OpLsr: begin
                sh     = {alu_a, 16'h0000} >> alu_b[3:0];
                res    = sh[31:16];
                c_flag = sh[15];
            end
            OpLsl: begin
                sh     = {16'h0000, alu_a} << alu_b[3:0];
                res    = sh[15:0];
                c_flag = sh[16];
            end
            OpMov: res = alu_b;
            OpAnd, OpTst: res = alu_a & alu_b;
            OpOr:  res = alu_a | alu_b;
            OpXor: res = alu_a ^ alu_b;
            OpNot: res = ~alu_a;
`ifdef ALU_MUL_EN
            OpMul: begin
                prod   = {16'h0000, alu_a} * {16'h0000, alu_b};
                res    = prod[15:0];
                c_flag = |prod[31:16];
            end
`endif
            default: known = 1'b0;
        endcase

        if (alu_store) begin
            alu_out   = alu_a;
            alu_flags = 4'b0000;
        end else if (!known) begin
            alu_out   = '0;
            alu_flags = 4'b0000;
        end else begin
            alu_out   = res;
            alu_flags = {res == 16'h0000, res[15], c_flag, v_flag};
        end
    end

endmodule

// File: tb/tb_alu_mem_unit.sv
// Bench for alu_mem_unit: directed cases plus randomized traffic, checked through a scoreboard
// queue drained by a monitor against a behavioural model of IM, DM and the ALU.
module tb_alu_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        im_en_write;
    logic [9:0]  im_address;
    logic [15:0] im_data_in;
    logic [15:0] im_data_out;
    logic        alu_store;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [3:0]  alu_flags;
    logic        dm_store;
    logic        dm_push;
    logic        dm_pop;
    logic [8:0]  dm_address;
    logic [15:0] dm_rez;
    logic [15:0] dm_sp;
    logic [15:0] dm_data_out;

    alu_mem_unit dut (
        .clk         (clk),
        .reset       (reset),
        .im_en_write (im_en_write),
        .im_address  (im_address),
        .im_data_in  (im_data_in),
        .im_data_out (im_data_out),
        .alu_store   (alu_store),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .dm_store    (dm_store),
        .dm_push     (dm_push),
        .dm_pop      (dm_pop),
        .dm_address  (dm_address),
        .dm_rez      (dm_rez),
        .dm_sp       (dm_sp),
        .dm_data_out (dm_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          sel;  // 0 im_data_out, 1 alu_out, 2 alu_flags, 3 dm_data_out
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event mon_ev;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] im_m [1024];
    bit          im_v [1024];
    logic [15:0] dm_m [512];

    initial begin
        forever begin
            @(mon_ev);
            while (sb_q.size() > 0) begin
                exp_t        e;
                logic [15:0] act;
                e = sb_q.pop_front();
                case (e.sel)
                    0:       act = im_data_out;
                    1:       act = alu_out;
                    2:       act = {12'h000, alu_flags};
                    default: act = dm_data_out;
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", e.nm, act, e.exp);
                end
            end
        end
    end

    task automatic expect_out(input string nm, input int sel, input logic [15:0] v);
        exp_t e;
        e.nm  = nm;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic present();
        #1;
        ->mon_ev;
    endtask

    task automatic idle();
        im_en_write = 1'b0;
        alu_store   = 1'b0;
        dm_store    = 1'b0;
        dm_push     = 1'b0;
        dm_pop      = 1'b0;
    endtask

    function automatic void ref_alu(input int op, input int ua, input int ub, input bit st,
                                    output logic [15:0] o, output logic [3:0] f);
        int r, s, sa, sb, amt;
        bit c, ov, known;
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        r = 0; s = 0; c = 0; ov = 0; known = 1; amt = ub % 16;
        case (op)
            0, 3, 7: r = 0;
            10:      begin r = ua + ub; c = (r > 65535); s = sa + sb; ov = 1; end
            11, 24:  begin r = ua - ub; c = (ua < ub); s = sa - sb; ov = 1; end
            12:      begin r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1); end
            13:      begin r = ua << amt; c = (amt != 0) && (((ua >> (16 - amt)) & 1) == 1); end
            16:      r = ub;
            17, 25:  r = ua & ub;
            18:      r = ua | ub;
            19:      r = ua ^ ub;
            20:      r = ~ua;
            26:      begin r = ua + 1; c = (r > 65535); s = sa + 1; ov = 1; end
            27:      begin r = ua - 1; c = (ua < 1); s = sa - 1; ov = 1; end
`ifdef ALU_MUL_EN
            21: begin
                longint p;
                p = longint'(ua) * longint'(ub);
                r = int'(p % 65536);
                c = (p >= 65536);
            end
`endif
            default: known = 0;
        endcase
        r = r & 'hFFFF;
        o = 16'(r);
        if (st) begin
            o = 16'(ua);
            f = 4'b0000;
        end else if (!known) begin
            o = 16'h0000;
            f = 4'b0000;
        end else begin
            f = {o == 16'h0000, o[15], c, ov && (s > 32767 || s < -32768)};
        end
    endfunction

    task automatic alu_dir(input string nm, input logic [5:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic st, input logic [15:0] eo,
                           input logic [3:0] ef);
        @(negedge clk);
        idle();
        alu_opcode = op; alu_a = a; alu_b = b; alu_store = st;
        expect_out({nm, ".out"}, 1, eo);
        expect_out({nm, ".flags"}, 2, {12'h000, ef});
        present();
    endtask

    task automatic dm_cycle(input string nm, input logic st, input logic pu, input logic po,
                            input logic [8:0] addr, input logic [15:0] sp,
                            input logic [15:0] rez, input logic [15:0] exp_rd);
        @(negedge clk);
        idle();
        dm_store = st; dm_push = pu; dm_pop = po;
        dm_address = addr; dm_sp = sp; dm_rez = rez;
        expect_out(nm, 3, exp_rd);
        present();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            4:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [8:0] pick_addr();
        if ($urandom_range(0, 1) == 1) return 9'h1F0 | 9'($urandom_range(0, 15));
        return 9'($urandom_range(0, 15));
    endfunction

    logic [15:0] prog [3];
    logic [5:0]  op_tab [17];

    initial begin
        logic [15:0] eo;
        logic [3:0]  ef;
        prog   = '{16'h4003, 16'h4200, 16'h2803};
        op_tab = '{6'd0, 6'd3, 6'd7, 6'd10, 6'd11, 6'd12, 6'd13, 6'd16, 6'd17, 6'd18, 6'd19,
                   6'd20, 6'd21, 6'd24, 6'd25, 6'd26, 6'd27};
        idle();
        reset = 1'b0;
        im_address = '0; im_data_in = '0;
        alu_a = '0; alu_b = '0; alu_opcode = '0;
        dm_address = 9'd7; dm_sp = 16'h01FF; dm_rez = '0;
        for (int i = 0; i < 1024; i++) im_v[i] = 0;
        for (int i = 0; i < 512; i++) dm_m[i] = '0;

        expect_out("reset.dm", 3, 16'h0000);
        present();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        expect_out("after_reset.dm", 3, 16'h0000);
        present();

        // IM load and readback
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            im_en_write = 1'b1; im_address = 10'(i); im_data_in = prog[i];
            im_m[i] = prog[i]; im_v[i] = 1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            im_address = 10'(i);
            expect_out($sformatf("im_load[%0d]", i), 0, prog[i]);
            present();
        end

        // ALU directed
        alu_dir("add3p3", 6'd10, 16'h0003, 16'h0003, 1'b0, 16'h0006, 4'b0000);
        alu_dir("inc_ffff", 6'd26, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b1010);
        alu_dir("add_wrap", 6'd10, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010);
        alu_dir("sub_ovf", 6'd11, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0001);
        alu_dir("cmp_eq", 6'd24, 16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b1000);
        alu_dir("cmp_lt", 6'd24, 16'h0004, 16'h0005, 1'b0, 16'hFFFF, 4'b0110);
        alu_dir("dec_0", 6'd27, 16'h0000, 16'h1234, 1'b0, 16'hFFFF, 4'b0110);
        alu_dir("mov_m1", 6'd16, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 4'b0100);
        alu_dir("store_a", 6'd10, 16'h1234, 16'h1111, 1'b1, 16'h1234, 4'b0000);
        alu_dir("hlt", 6'd0, 16'h5555, 16'h1111, 1'b0, 16'h0000, 4'b1000);
        alu_dir("bra", 6'd7, 16'h5555, 16'h1111, 1'b0, 16'h0000, 4'b1000);
        alu_dir("lsl_c", 6'd13, 16'h8001, 16'h0001, 1'b0, 16'h0002, 4'b0010);
        alu_dir("lsr_c", 6'd12, 16'h0001, 16'h0001, 1'b0, 16'h0000, 4'b1010);
        alu_dir("lsl_0", 6'd13, 16'h8001, 16'h0010, 1'b0, 16'h8001, 4'b0100);
        alu_dir("unknown", 6'd63, 16'h0001, 16'h0001, 1'b0, 16'h0000, 4'b0000);
`ifdef ALU_MUL_EN
        alu_dir("mul", 6'd21, 16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b1010);
`else
        alu_dir("mul_off", 6'd21, 16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b0000);
`endif

        // DM directed
        dm_cycle("store_old", 1'b1, 1'b0, 1'b0, 9'd7, 16'h0000, 16'hBEEF, 16'h0000);
        dm_cycle("store_rd", 1'b0, 1'b0, 1'b0, 9'd7, 16'h0000, 16'h0000, 16'hBEEF);
        dm_cycle("push", 1'b0, 1'b1, 1'b0, 9'd0, 16'h01FF, 16'h000A, 16'h0000);
        dm_cycle("pop", 1'b0, 1'b0, 1'b1, 9'd0, 16'h01FE, 16'h0000, 16'h000A);
        dm_cycle("push_store", 1'b1, 1'b1, 1'b0, 9'h020, 16'h0010, 16'h5555, 16'h0000);
        dm_cycle("ps_no_store", 1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, 16'h0000, 16'h0000);
        dm_cycle("ps_push", 1'b0, 1'b0, 1'b1, 9'h020, 16'h000F, 16'h0000, 16'h5555);
        dm_cycle("push_sp0", 1'b0, 1'b1, 1'b0, 9'd5, 16'hFE00, 16'h1234, 16'h0000);
        dm_cycle("pop_wrap", 1'b0, 1'b0, 1'b1, 9'd5, 16'h01FF, 16'h0000, 16'h1234);

        // Reset mid-cycle, store under reset, IM retention
        @(negedge clk);
        idle();
        dm_address = 9'd7;
        @(posedge clk);
        #2;
        reset = 1'b0;
        expect_out("rst_clear", 3, 16'h0000);
        present();
        @(negedge clk);
        dm_store = 1'b1; dm_rez = 16'hFFFF; dm_address = 9'd7;
        @(posedge clk);
        expect_out("rst_store", 3, 16'h0000);
        present();
        @(negedge clk);
        idle();
        reset = 1'b1;
        expect_out("rst_release", 3, 16'h0000);
        present();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            im_address = 10'(i);
            expect_out($sformatf("im_keep[%0d]", i), 0, prog[i]);
            present();
        end

        // Randomized traffic against the model (DM is all zero after the reset above)
        for (int i = 0; i < 512; i++) dm_m[i] = '0;
        for (int n = 0; n < 400; n++) begin
            int sp9;
            @(negedge clk);
            idle();
            im_address = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                im_en_write = 1'b1;
                im_data_in  = 16'($urandom);
            end
            alu_opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 16)];
            alu_a      = pick();
            alu_b      = pick();
            alu_store  = ($urandom_range(0, 7) == 0);
            dm_push    = ($urandom_range(0, 3) == 0);
            dm_store   = ($urandom_range(0, 3) == 0);
            dm_pop     = ($urandom_range(0, 2) == 0);
            dm_address = pick_addr();
            dm_sp      = {7'($urandom), pick_addr()};
            dm_rez     = 16'($urandom);
            sp9        = int'(dm_sp[8:0]);

            if (im_v[im_address]) expect_out("rnd.im", 0, im_m[im_address]);
            ref_alu(int'(alu_opcode), int'(alu_a), int'(alu_b), alu_store, eo, ef);
            expect_out($sformatf("rnd.alu op=%0d a=%h b=%h", alu_opcode, alu_a, alu_b), 1, eo);
            expect_out($sformatf("rnd.flags op=%0d a=%h b=%h", alu_opcode, alu_a, alu_b), 2,
                       {12'h000, ef});
            expect_out("rnd.dm", 3, dm_pop ? dm_m[(sp9 + 1) % 512] : dm_m[dm_address]);
            present();

            if (im_en_write) begin
                im_m[im_address] = im_data_in;
                im_v[im_address] = 1;
            end
            if (dm_push) dm_m[sp9] = dm_rez;
            else if (dm_store) dm_m[dm_address] = dm_rez;
        end

        @(negedge clk);
        idle();
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
